// File: rtl/pd_vote_filter_if.sv
// ---------------------------------------------------------------------------
// pd_vote_filter_if
// Bundles the sample and decision signals of the phase-detector vote filter.
//   sample_valid  sampler -> filter   lead/lag valid this cycle
//   lead          sampler -> filter   DCO edge leads reference
//   lag           sampler -> filter   DCO edge lags reference
//   p_up          filter  -> ctrl     1-cycle pulse, lead majority
//   p_down        filter  -> ctrl     1-cycle pulse, lag majority
//   dec_valid     filter  -> ctrl     1-cycle pulse at every window close
//   busy          filter  -> ctrl     high while samples are discarded
//   vote_cnt      filter  -> ctrl     latched vote (only with PD_VOTE_OUT_EN)
// modport master: sampler/controller side; modport slave: the filter itself.
// Optional feature macro: PD_VOTE_OUT_EN.
// ---------------------------------------------------------------------------
interface pd_vote_filter_if;
  logic sample_valid;
  logic lead;
  logic lag;
  logic p_up;
  logic p_down;
  logic dec_valid;
  logic busy;
`ifdef PD_VOTE_OUT_EN
  logic signed [8:0] vote_cnt;

  modport master (output sample_valid, lead, lag,
                  input  p_up, p_down, dec_valid, busy, vote_cnt);
  modport slave  (input  sample_valid, lead, lag,
                  output p_up, p_down, dec_valid, busy, vote_cnt);
`else
  modport master (output sample_valid, lead, lag,
                  input  p_up, p_down, dec_valid, busy);
  modport slave  (input  sample_valid, lead, lag,
                  output p_up, p_down, dec_valid, busy);
`endif
endinterface

// File: rtl/pd_vote_filter.sv
// ---------------------------------------------------------------------------
// pd_vote_filter
// Majority-vote filter between the bang-bang phase sampler and the PLL
// controller. Collects WINDOW valid lead/lag samples, emits at most one
// p_up/p_down decision per window, then holds off while the DCO settles.
// Ports:
//   phase_clk  in  clock, all logic on posedge
//   reset      in  synchronous active-high reset
//   bus        pd_vote_filter_if.slave (sample_valid/lead/lag in,
//              p_up/p_down/dec_valid/busy[/vote_cnt] out)
// Optional feature macro: PD_VOTE_OUT_EN adds the latched vote_cnt output.
// ---------------------------------------------------------------------------
module pd_vote_filter #(
  parameter int WINDOW  = 8,
  parameter int THRESH  = 3,
  parameter int SETTLE  = 4,
  parameter int HOLDOFF = 2
) (
  input  logic              phase_clk,
  input  logic              reset,
  pd_vote_filter_if.slave   bus
);

  localparam logic [7:0]        WIN_L  = 8'(WINDOW);
  localparam logic [7:0]        SET_L  = 8'(SETTLE);
  localparam logic [7:0]        HOLD_L = 8'(HOLDOFF);
  localparam logic signed [8:0] THR_P  = 9'(THRESH);
  localparam logic signed [8:0] THR_N  = -THR_P;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DECIDE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t            r_state;
  logic signed [8:0] r_vote;
  logic [7:0]        r_nsamp;
  logic [7:0]        r_wait;
  logic              r_p_up;
  logic              r_p_down;
  logic              r_dec_valid;
  logic              r_busy;
`ifdef PD_VOTE_OUT_EN
  logic signed [8:0] r_vote_cnt;
`endif

  logic signed [8:0] w_vote_nxt;
  logic [7:0]        w_nsamp_nxt;
  logic              w_win_full;
  logic              w_settle_done;
  logic              w_hold_done;
  logic              w_up;
  logic              w_down;

  // Contribution of one sample: a clean lead or lag moves the vote, an
  // ambiguous sample (both or neither) carries no information.
  function automatic logic signed [8:0] vote_step(input logic lead, input logic lag);
    logic signed [8:0] step;
    case ({lead, lag})
      2'b10:   step = 9'sd1;
      2'b01:   step = -9'sd1;
      default: step = 9'sd0;
    endcase
    return step;
  endfunction

  // Next-sample arithmetic, wait-counter terminal detection, decision compare.
  always_comb begin
    w_vote_nxt    = r_vote + vote_step(bus.lead, bus.lag);
    w_nsamp_nxt   = r_nsamp + 8'd1;
    w_win_full    = (w_nsamp_nxt == WIN_L);
    // A zero-length wait leaves its state after a single cycle.
    w_settle_done = (SET_L == 8'd0) || (r_wait == (SET_L - 8'd1));
    w_hold_done   = (HOLD_L == 8'd0) || (r_wait == (HOLD_L - 8'd1));
    w_up          = (r_vote >= THR_P);
    w_down        = (r_vote <= THR_N);
  end

  // Vote FSM with registered decision outputs.
  always_ff @(posedge phase_clk) begin
    if (reset) begin
      r_state     <= ST_SETTLE;
      r_vote      <= 9'sd0;
      r_nsamp     <= 8'd0;
      r_wait      <= 8'd0;
      r_p_up      <= 1'b0;
      r_p_down    <= 1'b0;
      r_dec_valid <= 1'b0;
      r_busy      <= 1'b1;
`ifdef PD_VOTE_OUT_EN
      r_vote_cnt  <= 9'sd0;
`endif
    end else begin
      // Pulses last exactly one cycle unless DECIDE sets them below.
      r_p_up      <= 1'b0;
      r_p_down    <= 1'b0;
      r_dec_valid <= 1'b0;
      case (r_state)
        ST_SETTLE: begin
          if (w_settle_done) begin
            r_state <= ST_ACCUM;
            r_busy  <= 1'b0;
            r_wait  <= 8'd0;
          end else begin
            r_wait  <= r_wait + 8'd1;
          end
        end
        ST_ACCUM: begin
          if (bus.sample_valid) begin
            r_vote  <= w_vote_nxt;
            r_nsamp <= w_nsamp_nxt;
            if (w_win_full) begin
              r_state <= ST_DECIDE;
            end else begin
              r_state <= ST_ACCUM;
            end
          end else begin
            r_state <= ST_ACCUM;
          end
        end
        ST_DECIDE: begin
          r_p_up      <= w_up;
          r_p_down    <= w_down;
          r_dec_valid <= 1'b1;
          r_vote      <= 9'sd0;
          r_nsamp     <= 8'd0;
`ifdef PD_VOTE_OUT_EN
          r_vote_cnt  <= r_vote;
`endif
          // Only an emitted decision changes the DCO code and needs holdoff.
          if ((w_up || w_down) && (HOLD_L != 8'd0)) begin
            r_state <= ST_HOLD;
            r_busy  <= 1'b1;
            r_wait  <= 8'd0;
          end else begin
            r_state <= ST_ACCUM;
          end
        end
        ST_HOLD: begin
          if (w_hold_done) begin
            r_state <= ST_ACCUM;
            r_busy  <= 1'b0;
            r_wait  <= 8'd0;
          end else begin
            r_wait  <= r_wait + 8'd1;
          end
        end
        default: begin
          r_state <= ST_SETTLE;
          r_vote  <= 9'sd0;
          r_nsamp <= 8'd0;
          r_wait  <= 8'd0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.p_up      = r_p_up;
  assign bus.p_down    = r_p_down;
  assign bus.dec_valid = r_dec_valid;
  assign bus.busy      = r_busy;
`ifdef PD_VOTE_OUT_EN
  assign bus.vote_cnt  = r_vote_cnt;
`endif

endmodule

// File: tb/tb_pd_vote_filter.sv
// ---------------------------------------------------------------------------
// tb_pd_vote_filter
// Self-checking bench for pd_vote_filter (WINDOW=8 THRESH=3 SETTLE=4
// HOLDOFF=2). Expected window results are queued when a window is driven and
// compared when the filter raises dec_valid. Optional feature macro:
// PD_VOTE_OUT_EN (vote_cnt checks).
// ---------------------------------------------------------------------------
module tb_pd_vote_filter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pd_vote_filter_if bus();

  pd_vote_filter #(
    .WINDOW (8),
    .THRESH (3),
    .SETTLE (4),
    .HOLDOFF(2)
  ) dut (
    .phase_clk(clk),
    .reset    (reset),
    .bus      (bus)
  );

  typedef struct packed {
    logic       up;
    logic       down;
    logic [8:0] vote;
  } exp_t;

  exp_t sb_q[$];
  exp_t m_exp;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int v);
    exp_t e;
    e.up   = (v >= 3);
    e.down = (v <= -3);
    e.vote = 9'(v);
    sb_q.push_back(e);
  endtask

  // Scoreboard: every window close must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.dec_valid) begin
      if (sb_q.size() == 0) begin
        check_value("sb_unexpected", 32'd1, 32'd0);
      end else begin
        m_exp = sb_q.pop_front();
        check_value("sb_up",   {31'd0, bus.p_up},   {31'd0, m_exp.up});
        check_value("sb_down", {31'd0, bus.p_down}, {31'd0, m_exp.down});
`ifdef PD_VOTE_OUT_EN
        check_value("sb_vote", {23'd0, bus.vote_cnt}, {23'd0, m_exp.vote});
`endif
      end
    end else if (bus.p_up || bus.p_down) begin
      check_value("pulse_no_dec", {30'd0, bus.p_up, bus.p_down}, 32'd0);
    end
    if (bus.p_up && bus.p_down) begin
      check_value("both_pulse", 32'd1, 32'd0);
    end
  end

  // Drive one full window from ACCUM with an empty vote, then verify timing.
  task automatic send_window(input logic [7:0] leads, input logic [7:0] lags);
    int   v;
    logic dec;
    v = 0;
    for (int i = 0; i < 8; i++) begin
      if (leads[i] && !lags[i]) v++;
      else if (lags[i] && !leads[i]) v--;
    end
    push_exp(v);
    dec = (v >= 3) || (v <= -3);
    for (int i = 0; i < 8; i++) begin
      bus.sample_valid = 1'b1;
      bus.lead         = leads[i];
      bus.lag          = lags[i];
      tick();
    end
    bus.sample_valid = 1'b0;
    bus.lead         = 1'b0;
    bus.lag          = 1'b0;
    check_value("win_early", {29'd0, bus.p_up, bus.p_down, bus.dec_valid}, 32'd0);
    tick();
    check_value("win_dec",  {31'd0, bus.dec_valid}, 32'd1);
    check_value("win_busy", {31'd0, bus.busy}, {31'd0, dec});
    tick();
    check_value("win_clr",   {31'd0, bus.dec_valid}, 32'd0);
    check_value("win_hold",  {31'd0, bus.busy}, {31'd0, dec});
`ifdef PD_VOTE_OUT_EN
    check_value("vote_hold", {23'd0, bus.vote_cnt}, {23'd0, 9'(v)});
`endif
    tick();
    check_value("win_idle", {31'd0, bus.busy}, 32'd0);
  endtask

  // Reset, release with continuous lead, check settle, latency and holdoff.
  task automatic run_from_reset();
    reset            = 1'b1;
    bus.sample_valid = 1'b0;
    bus.lead         = 1'b0;
    bus.lag          = 1'b0;
    tick();
    tick();
    check_value("rst_busy", {31'd0, bus.busy}, 32'd1);
    check_value("rst_outs", {29'd0, bus.p_up, bus.p_down, bus.dec_valid}, 32'd0);
    reset            = 1'b0;
    bus.sample_valid = 1'b1;
    bus.lead         = 1'b1;
    push_exp(8);
    for (int k = 0; k < 4; k++) begin
      check_value("settle_busy", {31'd0, bus.busy}, 32'd1);
      tick();
    end
    check_value("settle_done", {31'd0, bus.busy}, 32'd0);
    for (int k = 0; k < 8; k++) tick();
    check_value("lat_early", {31'd0, bus.p_up}, 32'd0);
    tick();
    check_value("lat_pulse", {31'd0, bus.p_up}, 32'd1);
    check_value("hold_busy", {31'd0, bus.busy}, 32'd1);
    tick();
    check_value("pulse_width", {31'd0, bus.p_up}, 32'd0);
    check_value("hold_busy2",  {31'd0, bus.busy}, 32'd1);
    tick();
    check_value("hold_end", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    reset            = 1'b1;
    bus.sample_valid = 1'b0;
    bus.lead         = 1'b0;
    bus.lag          = 1'b0;

    // Continuous lead from reset, then a second window straight after holdoff.
    run_from_reset();
    push_exp(8);
    for (int k = 0; k < 8; k++) tick();
    check_value("rep_early", {31'd0, bus.p_up}, 32'd0);
    tick();
    check_value("rep_pulse", {31'd0, bus.p_up}, 32'd1);
    bus.sample_valid = 1'b0;
    bus.lead         = 1'b0;
    for (int k = 0; k < 3; k++) tick();

    // 5 lag + 3 lead: below threshold, no holdoff.
    send_window(8'b0000_0111, 8'b1111_1000);
    // 6 lag + 2 both: vote -6, p_down.
    send_window(8'b0000_0011, 8'b1111_1111);
    // Threshold boundaries.
    send_window(8'b0000_0111, 8'b0000_0000);
    send_window(8'b0000_0000, 8'b0000_0111);
    send_window(8'b0000_0011, 8'b0000_0000);

    // Alternating sample_valid: invalid cycles must not count.
    push_exp(8);
    bus.lead = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.sample_valid = ((i % 2) == 0);
      tick();
      if (i == 14) check_value("tog_early", {31'd0, bus.p_up}, 32'd0);
    end
    check_value("tog_pulse", {31'd0, bus.p_up}, 32'd1);
    bus.sample_valid = 1'b0;
    bus.lead         = 1'b0;
    for (int k = 0; k < 3; k++) tick();

    // Reset after 7 lead samples discards the partial window.
    bus.sample_valid = 1'b1;
    bus.lead         = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    reset            = 1'b1;
    bus.sample_valid = 1'b0;
    bus.lead         = 1'b0;
    tick();
    check_value("rst_mid", {29'd0, bus.p_up, bus.p_down, bus.dec_valid}, 32'd0);
    run_from_reset();
    bus.sample_valid = 1'b0;
    bus.lead         = 1'b0;
    for (int k = 0; k < 3; k++) tick();

    // Random windows.
    for (int r = 0; r < 12; r++) begin
      send_window(8'($urandom()), 8'($urandom()));
    end

    tick();
    check_value("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
